// File: rtl/sprite_blitter_if.sv
// Sprite ROM read port and frame-buffer write port of the sprite blitter.
// master = blitter, slave = ROM + frame-buffer memory side.
interface sprite_blitter_if #(
  parameter int ROM_AW = 12,
  parameter int PIX_W  = 4,
  parameter int FB_AW  = 19
);
  // ROM: rom_data is the word at the rom_addr presented one cycle earlier.
  // FB: a write transfers on a rising edge where fb_we=1 and fb_ready=1; while
  // fb_we=1 and fb_ready=0, fb_addr and fb_data hold stable until accepted.
  logic [ROM_AW-1:0] rom_addr;
  logic [PIX_W-1:0]  rom_data;
  logic              fb_we;
  logic [FB_AW-1:0]  fb_addr;
  logic [PIX_W-1:0]  fb_data;
  logic              fb_ready;

  modport master (
    output rom_addr,
    input  rom_data,
    output fb_we,
    output fb_addr,
    output fb_data,
    input  fb_ready
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  fb_we,
    input  fb_addr,
    input  fb_data,
    output fb_ready
  );
endinterface

// File: rtl/sprite_blitter.sv
// Copies one sprite from a synchronous ROM into the frame buffer with transparency and clipping.
// Optional BLIT_HFLIP_EN adds an hflip input that mirrors each sprite row on fetch.
module sprite_blitter #(
  parameter int               SPR_W       = 57,
  parameter int               SPR_H       = 61,
  parameter int               ROM_AW      = 12,
  parameter int               PIX_W       = 4,
  parameter logic [PIX_W-1:0] TRANSPARENT = 4'h0,
  parameter int               FB_W        = 640,
  parameter int               FB_H        = 480,
  parameter int               FB_AW       = 19
) (
  input  logic        Clk,
  input  logic        Reset_n,
`ifdef BLIT_HFLIP_EN
  input  logic        hflip,
`endif
  input  logic        start,
  input  logic [11:0] x0,
  input  logic [11:0] y0,
  output logic        busy,
  output logic        done,
  output logic [1:0]  dbg_state,
  sprite_blitter_if.master bus
);

  localparam int CW = $clog2(SPR_W);
  localparam int RW = $clog2(SPR_H);
  localparam int SW = 14;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t            state;
  logic [11:0]       x0_r, y0_r;
  logic              flip_r;
  logic [RW-1:0]     row;
  logic [CW-1:0]     col;
  logic [ROM_AW-1:0] iss_addr;
  logic              s1_valid;
  logic [RW-1:0]     s1_row;
  logic [CW-1:0]     s1_col;
  logic [ROM_AW-1:0] s1_addr;
  logic              out_we;
  logic [FB_AW-1:0]  out_addr;
  logic [PIX_W-1:0]  out_data;

  logic              hflip_in;
  logic              out_adv, stall, last_pix, row_end, vis;
  logic [SW-1:0]     sx, sy;
  logic [FB_AW-1:0]  pix_addr;
  logic [ROM_AW-1:0] nxt_addr, first_addr;

`ifdef BLIT_HFLIP_EN
  assign hflip_in = hflip;
`else
  assign hflip_in = 1'b0;
`endif

  assign out_adv  = !out_we || bus.fb_ready;
  assign stall    = s1_valid && !out_adv;
  assign row_end  = (col == CW'(SPR_W - 1));
  assign last_pix = row_end && (row == RW'(SPR_H - 1));

  // Screen coordinates of the S1 pixel as 14-bit two's-complement sums.
  assign sx = {{(SW-12){x0_r[11]}}, x0_r} + SW'(s1_col);
  assign sy = {{(SW-12){y0_r[11]}}, y0_r} + SW'(s1_row);
  assign vis = (bus.rom_data != TRANSPARENT) &&
               !sx[SW-1] && (sx < SW'(FB_W)) &&
               !sy[SW-1] && (sy < SW'(FB_H));
  assign pix_addr = FB_AW'(sy) * FB_AW'(FB_W) + FB_AW'(sx);

  // Mirrored rows walk down from the row's last word; at row end jump to the next row's last word.
  always_comb begin
    nxt_addr = iss_addr + ROM_AW'(1);
    if (flip_r) begin
      if (row_end) nxt_addr = iss_addr + ROM_AW'(2 * SPR_W - 1);
      else         nxt_addr = iss_addr - ROM_AW'(1);
    end
  end

  assign first_addr = hflip_in ? ROM_AW'(SPR_W - 1) : '0;

  // On a stall the ROM re-reads the held pixel so rom_data stays valid for it.
  assign bus.rom_addr = stall ? s1_addr : iss_addr;
  assign bus.fb_we    = out_we;
  assign bus.fb_addr  = out_addr;
  assign bus.fb_data  = out_data;
  assign dbg_state    = state;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      x0_r     <= '0;
      y0_r     <= '0;
      flip_r   <= 1'b0;
      row      <= '0;
      col      <= '0;
      iss_addr <= '0;
      s1_valid <= 1'b0;
      s1_row   <= '0;
      s1_col   <= '0;
      s1_addr  <= '0;
      out_we   <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
    end else begin
      done <= 1'b0;

      if (out_adv) begin
        if (s1_valid && vis) begin
          out_we   <= 1'b1;
          out_addr <= pix_addr;
          out_data <= bus.rom_data;
        end else begin
          out_we <= 1'b0;
        end
      end

      if (!stall) begin
        s1_valid <= (state == RUN);
        s1_row   <= row;
        s1_col   <= col;
        s1_addr  <= iss_addr;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            x0_r     <= x0;
            y0_r     <= y0;
            flip_r   <= hflip_in;
            row      <= '0;
            col      <= '0;
            iss_addr <= first_addr;
          end
        end
        RUN: begin
          if (!stall) begin
            if (last_pix) begin
              state <= DRAIN;
            end else begin
              iss_addr <= nxt_addr;
              if (row_end) begin
                col <= '0;
                row <= row + RW'(1);
              end else begin
                col <= col + CW'(1);
              end
            end
          end
        end
        DRAIN: begin
          if (!s1_valid && out_adv) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Copies one sprite from a synchronous sprite ROM into the frame buffer at a given screen position. Drives the ROM read address and consumes its 4-bit palette-index output, which arrives one cycle after the address. Skips transparent pixels and clips against the screen edges. Sits between game logic, which issues start/x0/y0, and the frame-buffer write port.

## Interface
Parameters:
- SPR_W, 57: sprite width in pixels
- SPR_H, 61: sprite height in pixels
- ROM_AW, 12: ROM address width
- PIX_W, 4: palette index width
- TRANSPARENT, 4'h0: index that is never written
- FB_W, 640: screen width; FB_H, 480: screen height
- FB_AW, 19: frame-buffer address width

Ports:
- Clk  in  1  clock; one clock domain, all logic on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- start  in  1  blit request; sampled only when busy=0
- x0  in  12  signed screen x of sprite top-left; sampled with start
- y0  in  12  signed screen y of sprite top-left; sampled with start
- busy  out  1  blit in progress
- done  out  1  one-cycle pulse when the blit completes
- rom_addr  out  ROM_AW  ROM read address, row-major: row*SPR_W+col
- rom_data  in  PIX_W  ROM output; valid the cycle after rom_addr
- fb_we  out  1  write request
- fb_addr  out  FB_AW  (y0+row)*FB_W+(x0+col)
- fb_data  out  PIX_W  palette index to write
- fb_ready  in  1  write accepted on an edge where fb_we=1 and fb_ready=1

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE → RUN when start=1. On that edge, x0 and y0 are latched, busy goes to 1, and the pixel counters (row, col) are cleared to 0.
- start while busy=1 is ignored.
- Three-stage pipeline:
  - Issue: rom_addr presents pixel p.
  - S1: rom_data holds pixel p; its row, col and ROM address are tracked.
  - OUT: output register {fb_we, fb_addr, fb_data}.
- S1 transfers to OUT when OUT is empty or fb_ready=1.
- On transfer, the pixel is loaded into OUT (fb_we=1) only if all of these hold:
  - rom_data≠TRANSPARENT
  - 0≤x0+col<FB_W
  - 0≤y0+row<FB_H
- Otherwise the pixel is dropped, and OUT clears if its previous content was accepted.
- Stall: S1 is valid and OUT is full with fb_ready=0. During a stall:
  - Issue does not advance.
  - rom_addr re-presents S1's pixel address, so rom_data stays valid for that pixel.
  - fb_addr and fb_data hold stable.
- Counters:
  - col wraps at SPR_W-1 to 0 and row increments.
  - rom_addr is a running counter; no multiplier on the ROM side.
- fb_addr uses the sign-extended sums. It is computed only for on-screen pixels and truncated to FB_AW.
- After the last pixel (row=SPR_H-1, col=SPR_W-1) is issued, the FSM goes RUN → DRAIN.
- DRAIN → IDLE when S1 and OUT are both empty. On that edge done=1 for one cycle and busy=0.
- Fully off-screen sprite: no writes occur; the blit still runs all SPR_W*SPR_H pixels and then pulses done.

## Timing
- Reset values: busy=0, done=0, fb_we=0, fb_addr=0, fb_data=0, rom_addr=0; FSM in IDLE; pipeline empty.
- Reset_n low mid-blit: fb_we drops immediately (asynchronously), the blit is abandoned, and no done pulse is issued.
- start accepted at edge E0:
  - busy=1 and rom_addr=0 after E0.
  - rom_data for pixel 0 valid after E1.
  - fb_we=1 for pixel 0 (if written) after E2.
- Throughput with fb_ready=1: one pixel per cycle.
- Unstalled blit: the last pixel is in OUT after edge E(SPR_W*SPR_H+1). done pulses after the following edge, which is the edge that accepts the last write.
- A start asserted in the same cycle that done pulses is accepted (FSM is IDLE).

## Configuration
- BLIT_HFLIP_EN defined:
  - Adds input port hflip (1 bit), sampled with start.
  - When hflip=1, each row is fetched mirrored: rom_addr = row*SPR_W + (SPR_W-1-col). fb_addr is unchanged.
- Not defined: no hflip port, and fetch order is always row-major ascending.

## Test plan
- Reset: hold Reset_n=0 and toggle the other inputs → every output stays 0. Release → IDLE, busy=0.
- Blit at (0,0), ROM all 4'h3, fb_ready=1:
  - Exactly 3477 writes.
  - First write fb_addr=0.
  - Pixel (row 1, col 0) write at fb_addr=640.
  - Last write at fb_addr=60*640+56=38456.
  - done one edge after the last accept.
  - busy high for 3479 cycles.
- Transparency: ROM word 5 = 4'h0, blit at (100,50) → no write to 50*640+105; all other 3476 writes present.
- Clipping: blit at (-10,470) → exactly 470 writes (cols 10–56, rows 0–9). First fb_addr=470*640+0.
- Backpressure: repeat the (0,0) blit with fb_ready randomly 0/1 → write sequence identical to the unstalled run; fb_addr and fb_data stable during every stall.
- Control: start pulsed while busy → ignored, single done. Reset_n low at pixel 1000 → fb_we falls immediately and there is no done pulse. With BLIT_HFLIP_EN and hflip=1 at (0,0) → the first write has fb_addr=0 and data from ROM word 56.
